// File: rtl/datapath_unit.sv
// Accumulates up to eight button-entered bytes into a 16-bit sum shown on four hex seven-segment digits.
// Define SEG_ACTIVE_LOW_EN for active-low segment drive; default is active-high.
module datapath_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic [7:0] inputdata,
  output logic [6:0] disp3,
  output logic [6:0] disp2,
  output logic [6:0] disp1,
  output logic [6:0] disp0,
  output logic       inputdata_ready,
  output logic       loaddata
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        enter_q;
  logic        enter_rise;
  logic [7:0]  data_reg;
  logic [15:0] sum;
  logic [15:0] sum_nxt;
  logic [3:0]  count;
  logic [3:0]  count_nxt;

  // enter_q resets high so a button already held at reset release is not taken as an entry
  assign enter_rise = enter & ~enter_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      enter_q         <= 1'b1;
      data_reg        <= 8'd0;
      inputdata_ready <= 1'b0;
    end else begin
      enter_q         <= enter;
      inputdata_ready <= enter_rise;
      if (enter_rise) begin
        data_reg <= inputdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT;
      sum      <= 16'd0;
      count    <= 4'd0;
      loaddata <= 1'b0;
    end else begin
      state    <= state_nxt;
      sum      <= sum_nxt;
      count    <= count_nxt;
      loaddata <= (state_nxt == LOAD);
    end
  end

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    count_nxt = count;
    case (state)
      WAIT: begin
        if (inputdata_ready) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        sum_nxt   = sum + {8'd0, data_reg};
        count_nxt = count + 4'd1;
        state_nxt = (count_nxt == 4'd8) ? FULL : WAIT;
      end
      FULL: begin
        // a new entry after a full set starts a fresh accumulation
        if (inputdata_ready) begin
          state_nxt = LOAD;
          sum_nxt   = 16'd0;
          count_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = WAIT;
      end
    endcase
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  assign disp3 = hex_seg(sum[15:12]);
  assign disp2 = hex_seg(sum[11:8]);
  assign disp1 = hex_seg(sum[7:4]);
  assign disp0 = hex_seg(sum[3:0]);

endmodule

// File: tb/tb_datapath_unit.sv
// Directed self-checking bench for datapath_unit: reset, accumulation, restart, timing, held enter, reset in LOAD.
module tb_datapath_unit;

  logic       clk;
  logic       reset;
  logic       enter;
  logic [7:0] inputdata;
  logic [6:0] disp3;
  logic [6:0] disp2;
  logic [6:0] disp1;
  logic [6:0] disp0;
  logic       inputdata_ready;
  logic       loaddata;

  int checks = 0;
  int passed = 0;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  datapath_unit dut (
    .clk             (clk),
    .reset           (reset),
    .enter           (enter),
    .inputdata       (inputdata),
    .disp3           (disp3),
    .disp2           (disp2),
    .disp1           (disp1),
    .disp0           (disp0),
    .inputdata_ready (inputdata_ready),
    .loaddata        (loaddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  function automatic logic [27:0] disp_exp(input logic [15:0] s);
    return {seg(s[15:12]), seg(s[11:8]), seg(s[7:4]), seg(s[3:0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_disp(input string tag, input logic [15:0] s);
    check(tag, {4'd0, disp3, disp2, disp1, disp0}, {4'd0, disp_exp(s)});
  endtask

  // advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // enter high one cycle then low two cycles: E0, E1, E2
  task automatic do_entry(input logic [7:0] d);
    inputdata = d;
    enter     = 1'b1;
    step();
    enter = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enter     = 1'b0;
    inputdata = 8'd0;

    // reset state
    step();
    reset = 1'b0;
    check_disp("reset_disp", 16'h0000);
    check("reset_count", {28'd0, dut.count}, 32'd0);
    check("reset_state", {30'd0, dut.state}, {30'd0, S_WAIT});
    check("reset_ready", {31'd0, inputdata_ready}, 32'd0);
    check("reset_loaddata", {31'd0, loaddata}, 32'd0);
    step();

    // eight entries 4..32 -> 0x0090
    for (int i = 1; i <= 8; i++) do_entry(8'(4 * i));
    check_disp("sum8_disp", 16'h0090);
    check("sum8_state", {30'd0, dut.state}, {30'd0, S_FULL});
    check("sum8_count", {28'd0, dut.count}, 32'd8);

    // ninth entry restarts, then 37..61 -> 0x0178
    do_entry(8'd33);
    check_disp("restart_disp", 16'h0021);
    check("restart_count", {28'd0, dut.count}, 32'd1);
    for (int i = 0; i < 7; i++) do_entry(8'(37 + 4 * i));
    check_disp("second_set_disp", 16'h0178);
    check("second_set_state", {30'd0, dut.state}, {30'd0, S_FULL});

    // cycle-by-cycle timing of one 0xFF entry
    do_reset();
    step();
    inputdata = 8'hFF;
    enter     = 1'b1;
    step();
    enter = 1'b0;
    check("e0_ready", {31'd0, inputdata_ready}, 32'd1);
    check("e0_loaddata", {31'd0, loaddata}, 32'd0);
    step();
    check("e1_ready", {31'd0, inputdata_ready}, 32'd0);
    check("e1_loaddata", {31'd0, loaddata}, 32'd1);
    check_disp("e1_disp", 16'h0000);
    step();
    check("e2_loaddata", {31'd0, loaddata}, 32'd0);
    check_disp("e2_disp", 16'h00FF);

    // enter held high for ten cycles is a single entry
    do_reset();
    step();
    inputdata = 8'd5;
    enter     = 1'b1;
    repeat (10) step();
    enter = 1'b0;
    repeat (3) step();
    check_disp("held_disp", 16'h0005);
    check("held_count", {28'd0, dut.count}, 32'd1);

    // enter already high across reset release is not an entry
    enter     = 1'b1;
    inputdata = 8'd9;
    do_reset();
    repeat (4) step();
    check_disp("held_reset_disp", 16'h0000);
    check("held_reset_count", {28'd0, dut.count}, 32'd0);
    enter = 1'b0;
    step();

    // reset while in LOAD aborts the add
    inputdata = 8'h10;
    enter     = 1'b1;
    step();
    enter = 1'b0;
    step();
    check("abort_in_load", {31'd0, loaddata}, 32'd1);
    do_reset();
    check_disp("abort_disp", 16'h0000);
    check("abort_state", {30'd0, dut.state}, {30'd0, S_WAIT});
    check("abort_loaddata", {31'd0, loaddata}, 32'd0);
    repeat (3) step();
    check_disp("abort_later_disp", 16'h0000);
    for (int i = 0; i < 8; i++) do_entry(8'hFF);
    check_disp("max_disp", 16'h07F8);
    check("max_state", {30'd0, dut.state}, {30'd0, S_FULL});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
